score_event_sequencer: RTL and testbench
========================================

// Module: score_event_sequencer
// PURPOSE
//  Collects collision-score events from NUM_SRC independent sources (missiles, shots,
//  bonus pickups) and serialises them into single-cycle hit/bonus pulses for the
//  BCD score-digit counter chain. Guarantees one score per visible collision.
//  Enforces a settle gap between pulses so digit carries ripple before the next add.
//  Sits between the collision detectors and the scoreboard digit counters.
// PARAMETERS
//  NUM_SRC        4   number of event sources (2..8)
//  SETTLE_CYCLES  2   idle cycles after each issued pulse (1..15)
// PORTS
//  clk           in   1              system clock
//  resetN        in   1              async reset, active-low
//  gameOver      in   1              sync clear of all pending events, level
//  freeze        in   1              hold off issuing (pause); events still captured
//  src_hit       in   NUM_SRC        per-source regular-collision level
//  src_bonus     in   NUM_SRC        per-source bonus-collision level
//  score_hit     out  1              1-cycle regular-score pulse to digit counter
//  score_bonus   out  1              1-cycle bonus-score pulse to digit counter
//  score_enable  out  1              1-cycle enable, high with either pulse
//  grant_id      out  $clog2(NUM_SRC) source served by current/last pulse
//  pending       out  NUM_SRC        captured, not-yet-issued events
//  busy          out  1              high in ISSUE or SETTLE
//  dropped       out  1              1-cycle pulse: event merged into already-pending one
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, settle counter 0, last_grant=NUM_SRC-1
//    (source 0 gets first priority), internal prev-level and bonus flags 0.
//  - Capture: act[i]=src_hit[i]|src_bonus[i]. Rising edge of act[i] (1 now, 0 prev clk)
//    sets pending[i] on that clock; bonus_flag[i]=src_bonus[i]. Held levels never
//    re-trigger. Both hit and bonus high -> bonus.
//  - Edge on i while pending[i]=1: pending stays 1, bonus_flag[i] ORed in, dropped=1
//    for one cycle.
//  - FSM IDLE: if |pending && !freeze && !gameOver -> pick first pending source
//    scanning last_grant+1 upward with wrap (round-robin) -> ISSUE.
//  - ISSUE (exactly 1 cycle): score_enable=1, score_bonus=bonus_flag[g] else
//    score_hit=1, grant_id=g, clear pending[g]/bonus_flag[g], last_grant=g -> SETTLE.
//    Same-clock new edge on g re-sets pending[g] (new event wins over clear).
//  - SETTLE: all score outputs 0 for SETTLE_CYCLES cycles, then IDLE.
//    freeze does not abort ISSUE/SETTLE.
//  - Latency: first high sample at clock k -> pending at k -> score pulse in cycle
//    after clock k+1. Max issue rate: 1 per (SETTLE_CYCLES+1) clocks.
//  - gameOver high: pending, bonus_flag cleared, state forced IDLE, pulses 0 from next
//    cycle. Edges are ignored while high. prev-level still tracks, so a source held
//    through gameOver does not fire on release.
//  - Outputs registered; score_hit and score_bonus never high together.
//  - Async reset mid-ISSUE: pulse deasserts immediately, no partial score.
// CONFIGURATION
//  SCORE_EVT_STATS_EN defined: adds outputs evt_count[7:0] (issued pulses) and
//   drop_count[7:0] (dropped pulses). Both saturate at 255 and clear on resetN or
//   gameOver.
//  Undefined: ports absent, no stats logic; all other behaviour identical.
// TESTING
//  - Single src_hit[1] held 10 cycles -> exactly one score_hit, grant_id=1, 2 clocks
//    after rise; busy=1 for 1+SETTLE_CYCLES cycles.
//  - src_hit[0..3] rise same clock -> pulses served 0,1,2,3, spaced 3 clocks apart
//    (SETTLE=2); pending 4'b1111 -> 4'b0000.
//  - src_bonus[2] & src_hit[2] rise together -> one score_bonus, no score_hit.
//  - src_hit[3] pulses twice while pending (freeze=1) -> dropped=1 once, one pulse
//    after freeze drops.
//  - gameOver during SETTLE with pending=4'b0110 -> pending=0, no further pulses,
//    state IDLE.
//  - SCORE_EVT_STATS_EN: 300 issued events -> evt_count=255; gameOver -> 0.

Source files
------------

// File: rtl/score_event_sequencer.sv
// Serialises per-source collision events into spaced hit/bonus score pulses.
// Optional SCORE_EVT_STATS_EN adds saturating issued/dropped event counters.

// Per-source edge capture: pending bit, bonus flag, merge (drop) detect.
module score_evt_src (
  input  logic clk,
  input  logic resetN,
  input  logic i_hit,
  input  logic i_bonus,
  input  logic i_clr_all,
  input  logic i_clr,
  output logic o_pending,
  output logic o_bflag,
  output logic o_drop
);
  logic r_prev, r_pend, r_bflag;
  logic w_act, w_edge;

  assign w_act     = i_hit | i_bonus;
  assign w_edge    = w_act & ~r_prev & ~i_clr_all;
  assign o_drop    = w_edge & r_pend & ~i_clr;
  assign o_pending = r_pend;
  assign o_bflag   = r_bflag;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_prev  <= 1'b0;
      r_pend  <= 1'b0;
      r_bflag <= 1'b0;
    end else begin
      r_prev <= w_act;
      if (i_clr_all) begin
        r_pend  <= 1'b0;
        r_bflag <= 1'b0;
      end else if (w_edge) begin
        // a fresh edge on a source being granted starts a new event
        r_pend  <= 1'b1;
        r_bflag <= (r_pend & ~i_clr) ? (r_bflag | i_bonus) : i_bonus;
      end else if (i_clr) begin
        r_pend  <= 1'b0;
        r_bflag <= 1'b0;
      end
    end
  end
endmodule

module score_event_sequencer #(
  parameter int NUM_SRC       = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  logic                       gameOver,
  input  logic                       freeze,
  input  logic [NUM_SRC-1:0]         src_hit,
  input  logic [NUM_SRC-1:0]         src_bonus,
  output logic                       score_hit,
  output logic                       score_bonus,
  output logic                       score_enable,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic [NUM_SRC-1:0]         pending,
  output logic                       busy,
`ifdef SCORE_EVT_STATS_EN
  output logic [7:0]                 evt_count,
  output logic [7:0]                 drop_count,
`endif
  output logic                       dropped
);
  localparam int GW = $clog2(NUM_SRC);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SETTLE} state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_cnt, w_cnt_nxt;
  logic [GW-1:0]      r_last, w_pick, w_idx;
  logic               w_found, w_arb_ok, w_issue;
  logic [NUM_SRC-1:0] w_bflag, w_drop, w_clr;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    score_evt_src u_src (
      .clk      (clk),
      .resetN   (resetN),
      .i_hit    (src_hit[i]),
      .i_bonus  (src_bonus[i]),
      .i_clr_all(gameOver),
      .i_clr    (w_clr[i]),
      .o_pending(pending[i]),
      .o_bflag  (w_bflag[i]),
      .o_drop   (w_drop[i])
    );
  end

  // round-robin: first pending source after the last one served
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      w_idx = GW'((int'(r_last) + k) % NUM_SRC);
      if (!w_found && pending[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  assign w_arb_ok = w_found & ~freeze & ~gameOver;

  // the last settle cycle arbitrates like IDLE, giving one pulse per SETTLE+1 clocks
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue     = 1'b0;
    case (r_state)
      S_IDLE: if (w_arb_ok) begin
        w_state_nxt = S_ISSUE;
        w_issue     = 1'b1;
      end
      S_ISSUE: begin
        w_state_nxt = S_SETTLE;
        w_cnt_nxt   = 4'(SETTLE_CYCLES);
      end
      S_SETTLE: begin
        if (r_cnt > 4'd1) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_cnt_nxt = '0;
          if (w_arb_ok) begin
            w_state_nxt = S_ISSUE;
            w_issue     = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (gameOver) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_issue     = 1'b0;
    end
  end

  assign w_clr = w_issue ? (NUM_SRC'(1) << w_pick) : '0;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last       <= GW'(NUM_SRC - 1);
      score_hit    <= 1'b0;
      score_bonus  <= 1'b0;
      score_enable <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      score_enable <= w_issue;
      score_bonus  <= w_issue &  w_bflag[w_pick];
      score_hit    <= w_issue & ~w_bflag[w_pick];
      busy         <= (w_state_nxt != S_IDLE);
      dropped      <= |w_drop;
      if (w_issue) begin
        grant_id <= w_pick;
        r_last   <= w_pick;
      end
    end
  end

`ifdef SCORE_EVT_STATS_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      evt_count  <= '0;
      drop_count <= '0;
    end else if (gameOver) begin
      evt_count  <= '0;
      drop_count <= '0;
    end else begin
      if (w_issue && evt_count != 8'hFF)     evt_count  <= evt_count + 8'd1;
      if (|w_drop && drop_count != 8'hFF)    drop_count <= drop_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_score_event_sequencer.sv
// Scoreboard bench for score_event_sequencer (NUM_SRC=4, SETTLE_CYCLES=2).
module tb_score_event_sequencer;
  logic       clk = 1'b0;
  logic       resetN, gameOver, freeze;
  logic [3:0] src_hit, src_bonus;
  logic       score_hit, score_bonus, score_enable, busy, dropped;
  logic [1:0] grant_id;
  logic [3:0] pending;
`ifdef SCORE_EVT_STATS_EN
  logic [7:0] evt_count, drop_count;
`endif

  typedef struct { logic [1:0] id; logic bonus; } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0, n_pulses = 0, n_drops = 0;

  always #5 clk = ~clk;

  score_event_sequencer #(.NUM_SRC(4), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .resetN(resetN), .gameOver(gameOver), .freeze(freeze),
    .src_hit(src_hit), .src_bonus(src_bonus),
    .score_hit(score_hit), .score_bonus(score_bonus), .score_enable(score_enable),
    .grant_id(grant_id), .pending(pending), .busy(busy),
`ifdef SCORE_EVT_STATS_EN
    .evt_count(evt_count), .drop_count(drop_count),
`endif
    .dropped(dropped)
  );

  // scoreboard monitor: every pulse must match the oldest expected event
  always @(negedge clk) begin
    if (resetN) begin
      if (score_hit && score_bonus) begin
        errors++;
        $display("FAIL both_pulses: hit=%b bonus=%b, required never both", score_hit, score_bonus);
      end
      if (score_enable) begin
        n_pulses++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: grant=%0d bonus=%b, required no pulse", grant_id, score_bonus);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (grant_id !== e.id || score_bonus !== e.bonus || score_hit !== !e.bonus) begin
            errors++;
            $display("FAIL pulse: grant=%0d hit=%b bonus=%b, required grant=%0d bonus=%b",
                     grant_id, score_hit, score_bonus, e.id, e.bonus);
          end
        end
      end else if (score_hit || score_bonus) begin
        checks++;
        errors++;
        $display("FAIL enable: hit=%b bonus=%b without score_enable", score_hit, score_bonus);
      end
      if (dropped) n_drops++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetN = 1'b0; gameOver = 1'b0; freeze = 1'b0; src_hit = '0; src_bonus = '0;
    q.delete();
    step(2);
    resetN = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    resetN = 1'b0; gameOver = 1'b0; freeze = 1'b0; src_hit = '0; src_bonus = '0;
    step(1);
    checks++;
    if ({score_hit, score_bonus, score_enable, busy, dropped, grant_id, pending} !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all zero",
               {score_hit, score_bonus, score_enable, busy, dropped, grant_id, pending});
    end
    resetN = 1'b1;
    step(1);
  endtask

  task automatic test_single();
    int p0, nbusy;
    apply_reset();
    p0 = n_pulses; nbusy = 0;
    src_hit[1] = 1'b1;
    q.push_back('{id: 2'd1, bonus: 1'b0});
    step(1);
    checks++;
    if (pending !== 4'b0010 || score_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_capture: pending=%b en=%b, required 0010 0", pending, score_enable);
    end
    step(1);
    checks++;
    if (score_hit !== 1'b1 || grant_id !== 2'd1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL single_latency: hit=%b grant=%0d pending=%b, required 1 1 0000",
               score_hit, grant_id, pending);
    end
    for (int c = 0; c < 9; c++) begin
      if (busy) nbusy++;
      step(1);
    end
    src_hit = '0;
    step(2);
    checks++;
    if (nbusy != 3) begin
      errors++;
      $display("FAIL single_busy: busy cycles=%0d, required 3", nbusy);
    end
    checks++;
    if (n_pulses - p0 != 1) begin
      errors++;
      $display("FAIL single_count: pulses=%0d, required 1", n_pulses - p0);
    end
  endtask

  task automatic test_round_robin();
    int at[$];
    apply_reset();
    src_hit = 4'b1111;
    for (int i = 0; i < 4; i++) q.push_back('{id: 2'(i), bonus: 1'b0});
    step(1);
    checks++;
    if (pending !== 4'b1111) begin
      errors++;
      $display("FAIL rr_pending_full: pending=%b, required 1111", pending);
    end
    for (int n = 1; n <= 14; n++) begin
      step(1);
      if (score_enable) at.push_back(n);
    end
    checks++;
    if (at.size() != 4 || at[0] != 1 || at[1] != 4 || at[2] != 7 || at[3] != 10) begin
      errors++;
      $display("FAIL rr_spacing: count=%0d first=%0d last=%0d, required 4 pulses at 1,4,7,10",
               at.size(), at.size() > 0 ? at[0] : -1, at.size() > 0 ? at[at.size()-1] : -1);
    end
    checks++;
    if (pending !== 4'b0000 || q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain: pending=%b queue=%0d, required 0000 0", pending, q.size());
    end
    src_hit = '0;
    step(2);
  endtask

  task automatic test_bonus();
    int p0;
    apply_reset();
    p0 = n_pulses;
    src_hit[2] = 1'b1; src_bonus[2] = 1'b1;
    q.push_back('{id: 2'd2, bonus: 1'b1});
    step(2);
    checks++;
    if (score_bonus !== 1'b1 || score_hit !== 1'b0) begin
      errors++;
      $display("FAIL bonus_priority: hit=%b bonus=%b, required 0 1", score_hit, score_bonus);
    end
    step(8);
    src_hit = '0; src_bonus = '0;
    step(2);
    checks++;
    if (n_pulses - p0 != 1) begin
      errors++;
      $display("FAIL bonus_count: pulses=%0d, required 1", n_pulses - p0);
    end
  endtask

  task automatic test_drop();
    int p0, d0;
    apply_reset();
    p0 = n_pulses; d0 = n_drops;
    freeze = 1'b1;
    src_hit[3] = 1'b1; step(1);
    src_hit[3] = 1'b0; step(1);
    src_hit[3] = 1'b1; step(1);
    checks++;
    if (dropped !== 1'b1) begin
      errors++;
      $display("FAIL drop_pulse: dropped=%b, required 1", dropped);
    end
    src_hit[3] = 1'b0;
    step(4);
    checks++;
    if (n_drops - d0 != 1 || n_pulses != p0 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL drop_frozen: drops=%0d pulses=%0d pending=%b, required 1 0 1000",
               n_drops - d0, n_pulses - p0, pending);
    end
    q.push_back('{id: 2'd3, bonus: 1'b0});
    freeze = 1'b0;
    step(6);
    checks++;
    if (n_pulses - p0 != 1 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL drop_release: pulses=%0d pending=%b, required 1 0000", n_pulses - p0, pending);
    end
  endtask

  task automatic test_back_to_back();
    int p0, d0;
    apply_reset();
    p0 = n_pulses; d0 = n_drops;
    q.push_back('{id: 2'd1, bonus: 1'b0});
    q.push_back('{id: 2'd1, bonus: 1'b0});
    src_hit[1] = 1'b1; step(1);
    src_hit[1] = 1'b0; step(1);
    src_hit[1] = 1'b1; step(1);
    src_hit[1] = 1'b0; step(1);
    checks++;
    if (score_enable !== 1'b0 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_settle: en=%b pending=%b, required 0 0010", score_enable, pending);
    end
    step(1);
    checks++;
    if (score_enable !== 1'b1) begin
      errors++;
      $display("FAIL b2b_spacing: en=%b, required 1 three clocks after first pulse", score_enable);
    end
    step(4);
    checks++;
    if (n_pulses - p0 != 2 || n_drops != d0) begin
      errors++;
      $display("FAIL b2b_count: pulses=%0d drops=%0d, required 2 0", n_pulses - p0, n_drops - d0);
    end
  endtask

  task automatic test_gameover();
    int p0;
    apply_reset();
    p0 = n_pulses;
    src_hit = 4'b0111;
    q.push_back('{id: 2'd0, bonus: 1'b0});
    step(3);
    checks++;
    if (pending !== 4'b0110 || busy !== 1'b1) begin
      errors++;
      $display("FAIL go_setup: pending=%b busy=%b, required 0110 1", pending, busy);
    end
    gameOver = 1'b1;
    step(1);
    checks++;
    if (pending !== 4'b0000 || busy !== 1'b0 || score_enable !== 1'b0) begin
      errors++;
      $display("FAIL go_clear: pending=%b busy=%b en=%b, required 0000 0 0", pending, busy, score_enable);
    end
    step(1);
    gameOver = 1'b0;
    step(10);
    checks++;
    if (n_pulses - p0 != 1 || pending !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL go_release: pulses=%0d pending=%b busy=%b, required 1 0000 0",
               n_pulses - p0, pending, busy);
    end
    src_hit = '0;
    step(2);
  endtask

`ifdef SCORE_EVT_STATS_EN
  task automatic test_stats();
    apply_reset();
    for (int r = 0; r < 75; r++) begin
      for (int i = 0; i < 4; i++) q.push_back('{id: 2'(i), bonus: 1'b0});
      src_hit = 4'b1111; step(1);
      src_hit = 4'b0000; step(14);
    end
    checks++;
    if (evt_count !== 8'd255 || drop_count !== 8'd0) begin
      errors++;
      $display("FAIL stats_sat: evt=%0d drop=%0d, required 255 0", evt_count, drop_count);
    end
    gameOver = 1'b1; step(1);
    gameOver = 1'b0;
    checks++;
    if (evt_count !== 8'd0) begin
      errors++;
      $display("FAIL stats_clear: evt=%0d, required 0", evt_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_bonus();
    test_drop();
    test_back_to_back();
    test_gameover();
`ifdef SCORE_EVT_STATS_EN
    test_stats();
`endif
    step(2);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d expected pulses never seen, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
